// File: rtl/sid_cmd_uart_tx_pkg.sv
// SID command UART transmitter: shared types and constants.
// FSM encoding, frame shape and SID command layout.
package sid_cmd_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_ADDR,
    ST_SEND_DATA
  } state_e;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  localparam int SID_ADDR_W = 5;
  localparam logic [SID_ADDR_W-1:0] SID_DELAY_CMD = 5'h1f;

  typedef struct packed {
    logic [SID_ADDR_W-1:0] addr;
    logic [DATA_BITS-1:0]  data;
  } sid_cmd_t;

  function automatic logic [DATA_BITS-1:0] addr_byte(
    input logic [SID_ADDR_W-1:0] a
  );
    return {{(DATA_BITS-SID_ADDR_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/sid_cmd_uart_tx_txuart.sv
// Byte serializer: start, 8 data bits LSB first, stop.
// A start on the done cycle chains the next frame gap-free.
module txuart
  import sid_cmd_uart_tx_pkg::*;
#(
  parameter int DIV = 104
) (
  input  logic                 CLK_IN,
  input  logic                 RSTn_i,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam int SW = DATA_BITS + STOP_BITS;

  logic          active_q;
  logic [CW-1:0] baud_q;
  logic [BW-1:0] bit_q;
  logic [SW-1:0] sr_q;
  logic          tx_q;
  logic          bit_end;
  logic          load;

  assign bit_end = active_q && (baud_q == BAUD_LAST);
  assign done    = bit_end && (bit_q == BIT_LAST);
  assign load    = start && (!active_q || done);
  assign tx      = tx_q;

  // Bit timing, shift register and registered line driver.
  always_ff @(posedge CLK_IN or negedge RSTn_i) begin
    if (!RSTn_i) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      sr_q     <= '1;
      tx_q     <= 1'b1;
    end else if (load) begin
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      sr_q     <= {{STOP_BITS{1'b1}}, data};
      tx_q     <= 1'b0;
    end else if (done) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
    end else if (bit_end) begin
      baud_q   <= '0;
      bit_q    <= bit_q + BW'(1);
      tx_q     <= sr_q[0];
      sr_q     <= {1'b1, sr_q[SW-1:1]};
    end else if (active_q) begin
      baud_q   <= baud_q + CW'(1);
    end
  end

endmodule

// File: rtl/sid_cmd_uart_tx.sv
// SID register-write command queue feeding a UART.
// Each command goes out as an address byte then a data byte.
module sid_cmd_uart_tx
  import sid_cmd_uart_tx_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLK_IN,
  input  logic                        RSTn_i,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [SID_ADDR_W-1:0]       cmd_addr,
  input  logic [DATA_BITS-1:0]        cmd_data,
  output logic                        TX_o,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  sid_cmd_t       mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q;
  logic [AW-1:0]  rptr_q;
  logic [AW:0]    level_q;
  logic           rdy_en_q;
  logic           push;
  logic           pop;
  logic           empty;
  sid_cmd_t       head;

  state_e         state_q;
  state_e         state_d;
  sid_cmd_t       cur_q;
  logic           kick_q;
  logic           kick_d;
  logic           start;
  logic [DATA_BITS-1:0] tx_byte;
  logic           tx_done;

  assign empty      = (level_q == '0);
  assign cmd_ready  = rdy_en_q && (level_q != FULL);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rptr_q];
  assign fifo_level = level_q;
  assign busy       = (state_q != ST_IDLE) || !empty;

  // Accept gate opens one edge after reset release.
  always_ff @(posedge CLK_IN or negedge RSTn_i) begin
    if (!RSTn_i) rdy_en_q <= 1'b0;
    else         rdy_en_q <= 1'b1;
  end

  // Command storage, written at the tail.
  always_ff @(posedge CLK_IN) begin
    if (push) mem[wptr_q] <= '{addr: cmd_addr, data: cmd_data};
  end

  // Pointers and occupancy; push+pop leaves level unchanged.
  always_ff @(posedge CLK_IN or negedge RSTn_i) begin
    if (!RSTn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + (AW+1)'(1);
      else if (pop && !push) level_q <= level_q - (AW+1)'(1);
    end
  end

  // FSM state, current command and first-frame kick.
  always_ff @(posedge CLK_IN or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      kick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kick_q  <= kick_d;
      if (pop) cur_q <= head;
    end
  end

  // Next state, pops and byte selection for the serializer.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    kick_d  = 1'b0;
    start   = 1'b0;
    tx_byte = addr_byte(cur_q.addr);
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          kick_d  = 1'b1;
          state_d = ST_SEND_ADDR;
        end
      end
      ST_SEND_ADDR: begin
        if (kick_q) begin
          start = 1'b1;
        end else if (tx_done) begin
          start   = 1'b1;
          tx_byte = cur_q.data;
          state_d = ST_SEND_DATA;
        end
      end
      ST_SEND_DATA: begin
        if (tx_done) begin
          if (!empty) begin
            pop     = 1'b1;
            start   = 1'b1;
            tx_byte = addr_byte(head.addr);
            state_d = ST_SEND_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  txuart #(
    .DIV (DIV)
  ) u_txuart (
    .CLK_IN (CLK_IN),
    .RSTn_i (RSTn_i),
    .start  (start),
    .data   (tx_byte),
    .tx     (TX_o),
    .done   (tx_done)
  );

endmodule
